id_ex_hazard_stage: RTL and testbench
=====================================

// Module: id_ex_hazard_stage
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection, directly upstream of the EX-stage forwarding logic.
//  Captures decoded operands and control from ID and drives the ID_EX_* fields that EX muxes and forwarding consume.
//  On a load-use hazard it stalls PC and IF/ID for one cycle and inserts a bubble; a branch flush from EX also inserts a bubble.
//  Keeps a saturating count of stall cycles for performance debug.
// PARAMETERS
//  XLEN         32  datapath width (pc, register data, immediate)
//  CTRL_W       10  packed control width; bit0=RegW, bit1=MemR, bit2=MemW, bits[CTRL_W-1:3] opaque (ALUOp, ALUSrc, MemToReg, Branch)
//  STALL_CNT_W  16  width of the saturating stall-cycle counter
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  IF_ID_RegRs1   in   5        rs1 index of instruction in ID
//  IF_ID_RegRs2   in   5        rs2 index of instruction in ID
//  IF_ID_RegRd    in   5        rd index of instruction in ID
//  IF_ID_UseRs1   in   1        ID instruction reads rs1
//  IF_ID_UseRs2   in   1        ID instruction reads rs2 (0 for I-type/U-type/JAL)
//  ID_PC          in   XLEN     pc of ID instruction
//  ID_Rs1Data     in   XLEN     register-file read data rs1
//  ID_Rs2Data     in   XLEN     register-file read data rs2
//  ID_Imm         in   XLEN     sign-extended immediate
//  ID_Ctrl        in   CTRL_W   decoded control bundle
//  flush          in   1        branch/jump taken in EX; kill ID instruction
//  stall          out  1        load-use hazard this cycle (combinational)
//  PC_Write       out  1        ~stall; PC update enable
//  IF_ID_Write    out  1        ~stall; IF/ID register enable
//  ID_EX_PC, ID_EX_Rs1Data, ID_EX_Rs2Data, ID_EX_Imm  out  XLEN  registered ID fields
//  ID_EX_RegRs1, ID_EX_RegRs2, ID_EX_RegRd            out  5     registered register indices
//  ID_EX_Ctrl     out  CTRL_W   registered control; ID_EX_RegW=Ctrl[0], ID_EX_MemR=Ctrl[1], ID_EX_MemW=Ctrl[2] also broken out (1 bit each)
//  stall_count    out  STALL_CNT_W  number of stall cycles since reset, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): every ID_EX_* output and stall_count = 0 immediately; stall=0, PC_Write=IF_ID_Write=1 while in reset.
//  - hazard = ID_EX_MemR && ID_EX_RegRd!=0 && ((IF_ID_UseRs1 && ID_EX_RegRd==IF_ID_RegRs1) || (IF_ID_UseRs2 && ID_EX_RegRd==IF_ID_RegRs2)).
//  - stall = hazard && !flush (flush takes priority: the ID instruction is discarded anyway).
//  - Per rising edge, priority: flush > stall > capture.
//    flush or stall: bubble -> ID_EX_Ctrl=0, ID_EX_RegRd/Rs1/Rs2=0, data fields (PC, Rs1Data, Rs2Data, Imm)=0.
//    else: all ID_EX_* <= corresponding ID inputs, latency 1 cycle.
//  - Bubble has MemR=0, so stall never lasts more than one consecutive cycle per load; the stalled instruction re-presents next cycle and is captured.
//  - Forwarding (MEM_WB -> EX) resolves the loaded value after the bubble; this block never forwards.
//  - rd=x0 loads never stall. Loads whose rd matches only an unused source (UseRsN=0) never stall.
//  - stall_count increments by 1 on each rising edge with stall=1; holds at 2^STALL_CNT_W-1.
//  - Reset mid-stall: outputs clear asynchronously; first post-reset edge captures ID inputs normally.
//  - Two states are implicit: NORMAL (capture) and BUBBLE (one cycle after stall/flush); no other FSM state.
// TESTING
//  1. lw x5 in ID_EX (MemR=1,Rd=5), ID add uses rs1=5 -> stall=1, PC_Write=0, next ID_EX_Ctrl=0; cycle after, add captured, stall=0.
//  2. lw x5, ID addi rs2 field=5 but UseRs2=0 -> stall=0, addi captured next edge.
//  3. lw x0 in ID_EX, ID rs1=0 -> stall=0; and lw x7 with flush=1 same cycle, ID rs1=7 -> stall=0, bubble inserted, stall_count unchanged.
//  4. Back-to-back lw x1; lw x2 (rs1=x1) then add x2 -> stall on each dependent pair, stall_count=2, no double-stall.
//  5. STALL_CNT_W=2, force 5 hazard events -> stall_count reads 1,2,3,3,3.
//  6. Assert rst during stall cycle -> all ID_EX_* = 0 without clock edge, stall=0; deassert -> normal capture resumes.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load sitting in EX whose destination is read by the instruction in ID
// freezes PC and IF/ID for one cycle while a bubble enters EX. A taken
// branch/jump flush from EX also injects a bubble. The bubble carries
// MemR=0, so each load causes at most one stall cycle. A saturating
// counter of stall cycles is kept for performance debug.
module id_ex_hazard_stage #(
  parameter int XLEN        = 32,
  parameter int CTRL_W      = 10,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             IF_ID_RegRs1,
  input  logic [4:0]             IF_ID_RegRs2,
  input  logic [4:0]             IF_ID_RegRd,
  input  logic                   IF_ID_UseRs1,
  input  logic                   IF_ID_UseRs2,
  input  logic [XLEN-1:0]        ID_PC,
  input  logic [XLEN-1:0]        ID_Rs1Data,
  input  logic [XLEN-1:0]        ID_Rs2Data,
  input  logic [XLEN-1:0]        ID_Imm,
  input  logic [CTRL_W-1:0]      ID_Ctrl,
  input  logic                   flush,
  output logic                   stall,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic [XLEN-1:0]        ID_EX_PC,
  output logic [XLEN-1:0]        ID_EX_Rs1Data,
  output logic [XLEN-1:0]        ID_EX_Rs2Data,
  output logic [XLEN-1:0]        ID_EX_Imm,
  output logic [4:0]             ID_EX_RegRs1,
  output logic [4:0]             ID_EX_RegRs2,
  output logic [4:0]             ID_EX_RegRd,
  output logic [CTRL_W-1:0]      ID_EX_Ctrl,
  output logic                   ID_EX_RegW,
  output logic                   ID_EX_MemR,
  output logic                   ID_EX_MemW,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Control bundle bit positions; the rest of the bundle is opaque here.
  localparam int CTRL_REGW = 0;
  localparam int CTRL_MEMR = 1;
  localparam int CTRL_MEMW = 2;

  // One ID/EX slot: everything EX muxes and forwarding consume.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  id_ex_t id_slot;   // what ID presents this cycle
  id_ex_t ex_d;      // next value of the register
  id_ex_t ex_q;      // current EX-stage contents

  logic ex_load;     // EX holds a load with a real (non-x0) destination
  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic bubble;

  // Gather the ID-stage fields into one slot.
  always_comb begin
    id_slot          = '0;
    id_slot.pc       = ID_PC;
    id_slot.rs1_data = ID_Rs1Data;
    id_slot.rs2_data = ID_Rs2Data;
    id_slot.imm      = ID_Imm;
    id_slot.rs1      = IF_ID_RegRs1;
    id_slot.rs2      = IF_ID_RegRs2;
    id_slot.rd       = IF_ID_RegRd;
    id_slot.ctrl     = ID_Ctrl;
  end

  // Load-use detection: only sources the ID instruction actually reads count,
  // and a load to x0 never produces a value worth waiting for.
  always_comb begin
    ex_load = ex_q.ctrl[CTRL_MEMR] && (ex_q.rd != 5'd0);
    rs1_hit = IF_ID_UseRs1 && (ex_q.rd == IF_ID_RegRs1);
    rs2_hit = IF_ID_UseRs2 && (ex_q.rd == IF_ID_RegRs2);
    hazard  = ex_load && (rs1_hit || rs2_hit);
  end

  // A flush discards the ID instruction anyway, so it suppresses the stall.
  // Reset also forces the front end to run so IF restarts cleanly.
  assign stall       = hazard && !flush && !rst;
  assign PC_Write    = !stall;
  assign IF_ID_Write = !stall;

  // Either a flush or a stall puts a fully zeroed bubble into EX.
  assign bubble = flush || stall;

  // Next-slot select: bubble wins over normal capture.
  always_comb begin
    ex_d = id_slot;
    if (bubble) ex_d = '0;
  end

  // ID/EX register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              stall_count <= '0;
    else if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
  end

  assign ID_EX_PC      = ex_q.pc;
  assign ID_EX_Rs1Data = ex_q.rs1_data;
  assign ID_EX_Rs2Data = ex_q.rs2_data;
  assign ID_EX_Imm     = ex_q.imm;
  assign ID_EX_RegRs1  = ex_q.rs1;
  assign ID_EX_RegRs2  = ex_q.rs2;
  assign ID_EX_RegRd   = ex_q.rd;
  assign ID_EX_Ctrl    = ex_q.ctrl;
  assign ID_EX_RegW    = ex_q.ctrl[CTRL_REGW];
  assign ID_EX_MemR    = ex_q.ctrl[CTRL_MEMR];
  assign ID_EX_MemW    = ex_q.ctrl[CTRL_MEMW];

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: load-use stall, unused-source and
// x0 exemptions, flush priority, back-to-back loads, counter saturation on a
// narrow-counter instance, and asynchronous reset in the middle of a stall.
module tb_id_ex_hazard_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 10;

  // RegW|MemR plus an opaque MemToReg bit; ADD/ADDI carry RegW plus opaque bits
  localparam logic [CTRL_W-1:0] LW   = 10'h023;
  localparam logic [CTRL_W-1:0] ADD  = 10'h009;
  localparam logic [CTRL_W-1:0] ADDI = 10'h019;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_sat = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic use1 = 1'b0, use2 = 1'b0;
  logic [XLEN-1:0] pc = '0, d1 = '0, d2 = '0, imm = '0;
  logic [CTRL_W-1:0] ctrl = '0;
  logic flush = 1'b0;

  logic stall, pc_write, if_id_write;
  logic [XLEN-1:0] ex_pc, ex_d1, ex_d2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic ex_regw, ex_memr, ex_memw;
  logic [15:0] cnt;

  logic s_stall, s_pcw, s_ifw;
  logic [XLEN-1:0] s_pc, s_d1, s_d2, s_imm;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic [CTRL_W-1:0] s_ctrl;
  logic s_regw, s_memr, s_memw;
  logic [1:0] s_cnt;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_RegRs1(rs1), .IF_ID_RegRs2(rs2), .IF_ID_RegRd(rd),
    .IF_ID_UseRs1(use1), .IF_ID_UseRs2(use2),
    .ID_PC(pc), .ID_Rs1Data(d1), .ID_Rs2Data(d2), .ID_Imm(imm), .ID_Ctrl(ctrl),
    .flush(flush), .stall(stall), .PC_Write(pc_write), .IF_ID_Write(if_id_write),
    .ID_EX_PC(ex_pc), .ID_EX_Rs1Data(ex_d1), .ID_EX_Rs2Data(ex_d2), .ID_EX_Imm(ex_imm),
    .ID_EX_RegRs1(ex_rs1), .ID_EX_RegRs2(ex_rs2), .ID_EX_RegRd(ex_rd),
    .ID_EX_Ctrl(ex_ctrl), .ID_EX_RegW(ex_regw), .ID_EX_MemR(ex_memr), .ID_EX_MemW(ex_memw),
    .stall_count(cnt)
  );

  id_ex_hazard_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst_sat),
    .IF_ID_RegRs1(rs1), .IF_ID_RegRs2(rs2), .IF_ID_RegRd(rd),
    .IF_ID_UseRs1(use1), .IF_ID_UseRs2(use2),
    .ID_PC(pc), .ID_Rs1Data(d1), .ID_Rs2Data(d2), .ID_Imm(imm), .ID_Ctrl(ctrl),
    .flush(flush), .stall(s_stall), .PC_Write(s_pcw), .IF_ID_Write(s_ifw),
    .ID_EX_PC(s_pc), .ID_EX_Rs1Data(s_d1), .ID_EX_Rs2Data(s_d2), .ID_EX_Imm(s_imm),
    .ID_EX_RegRs1(s_rs1), .ID_EX_RegRs2(s_rs2), .ID_EX_RegRd(s_rd),
    .ID_EX_Ctrl(s_ctrl), .ID_EX_RegW(s_regw), .ID_EX_MemR(s_memr), .ID_EX_MemW(s_memw),
    .stall_count(s_cnt)
  );

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present an instruction in ID; data fields are derived from pc.
  task automatic set_id(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic u1, input logic u2, input logic [XLEN-1:0] p,
                        input logic [CTRL_W-1:0] c);
    rs1 = a; rs2 = b; rd = d; use1 = u1; use2 = u2;
    pc = p; d1 = p ^ 32'hA5A5_0000; d2 = p ^ 32'h5A5A_0000; imm = p + 32'h10;
    ctrl = c; #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1; #1;
    checks++; if (ex_ctrl !== '0 || ex_pc !== '0 || ex_rd !== '0) begin failures++; $display("FAIL reset_fields ctrl=%0h pc=%0h rd=%0d want 0", ex_ctrl, ex_pc, ex_rd); end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL reset_count got=%0d want 0", cnt); end
    checks++; if (stall !== 1'b0 || pc_write !== 1'b1 || if_id_write !== 1'b1) begin failures++; $display("FAIL reset_ctl stall=%b pcw=%b ifw=%b want 0/1/1", stall, pc_write, if_id_write); end
    set_id(5'd1, 5'd2, 5'd3, 1, 1, 32'h100, LW);
    tick();
    checks++; if (ex_ctrl !== '0 || ex_imm !== '0) begin failures++; $display("FAIL reset_hold ctrl=%0h imm=%0h want 0", ex_ctrl, ex_imm); end
    rst = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 0, 0, 32'h0, '0);
    tick();
  endtask

  task automatic test_load_use();
    set_id(5'd2, 5'd0, 5'd5, 1, 0, 32'h200, LW);          // lw x5, 0(x2)
    tick();
    checks++; if (ex_memr !== 1'b1 || ex_rd !== 5'd5 || ex_pc !== 32'h200) begin failures++; $display("FAIL lu_load memr=%b rd=%0d pc=%0h want 1/5/200", ex_memr, ex_rd, ex_pc); end
    set_id(5'd5, 5'd4, 5'd6, 1, 1, 32'h204, ADD);         // add x6, x5, x4
    checks++; if (stall !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0) begin failures++; $display("FAIL lu_stall stall=%b pcw=%b ifw=%b want 1/0/0", stall, pc_write, if_id_write); end
    tick(); exp_cnt++;
    checks++; if (ex_ctrl !== '0 || ex_rd !== '0 || ex_rs1 !== '0 || ex_pc !== '0 || ex_d1 !== '0) begin failures++; $display("FAIL lu_bubble ctrl=%0h rd=%0d rs1=%0d pc=%0h d1=%0h want 0", ex_ctrl, ex_rd, ex_rs1, ex_pc, ex_d1); end
    checks++; if (stall !== 1'b0 || cnt !== exp_cnt) begin failures++; $display("FAIL lu_after stall=%b cnt=%0d want 0/%0d", stall, cnt, exp_cnt); end
    tick();
    checks++; if (ex_ctrl !== ADD || ex_rd !== 5'd6 || ex_rs1 !== 5'd5 || ex_rs2 !== 5'd4 || ex_d1 !== (32'h204 ^ 32'hA5A5_0000) || ex_d2 !== (32'h204 ^ 32'h5A5A_0000) || ex_imm !== 32'h214) begin failures++; $display("FAIL lu_capture ctrl=%0h rd=%0d rs1=%0d rs2=%0d d1=%0h imm=%0h", ex_ctrl, ex_rd, ex_rs1, ex_rs2, ex_d1, ex_imm); end
  endtask

  task automatic test_unused_src();
    set_id(5'd2, 5'd0, 5'd5, 1, 0, 32'h300, LW);
    tick();
    set_id(5'd1, 5'd5, 5'd7, 1, 0, 32'h304, ADDI);        // rs2 field = 5, not read
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL unused_stall got=%b want 0", stall); end
    tick();
    checks++; if (ex_ctrl !== ADDI || ex_rd !== 5'd7 || ex_pc !== 32'h304 || cnt !== exp_cnt) begin failures++; $display("FAIL unused_capture ctrl=%0h rd=%0d pc=%0h cnt=%0d", ex_ctrl, ex_rd, ex_pc, cnt); end
  endtask

  task automatic test_x0_and_flush();
    set_id(5'd2, 5'd0, 5'd0, 1, 0, 32'h400, LW);          // lw x0
    tick();
    set_id(5'd0, 5'd0, 5'd8, 1, 1, 32'h404, ADD);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b want 0", stall); end
    tick();
    checks++; if (ex_ctrl !== ADD || ex_rd !== 5'd8) begin failures++; $display("FAIL x0_capture ctrl=%0h rd=%0d want %0h/8", ex_ctrl, ex_rd, ADD); end
    set_id(5'd2, 5'd0, 5'd7, 1, 0, 32'h408, LW);          // lw x7
    tick();
    set_id(5'd7, 5'd0, 5'd9, 1, 0, 32'h40C, ADDI);
    flush = 1'b1; #1;
    checks++; if (stall !== 1'b0 || pc_write !== 1'b1) begin failures++; $display("FAIL flush_stall stall=%b pcw=%b want 0/1", stall, pc_write); end
    tick();
    flush = 1'b0;
    checks++; if (ex_ctrl !== '0 || ex_rd !== '0 || ex_pc !== '0 || cnt !== exp_cnt) begin failures++; $display("FAIL flush_bubble ctrl=%0h rd=%0d pc=%0h cnt=%0d want 0/0/0/%0d", ex_ctrl, ex_rd, ex_pc, cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    set_id(5'd3, 5'd0, 5'd1, 1, 0, 32'h500, LW);          // lw x1
    tick();
    set_id(5'd1, 5'd0, 5'd2, 1, 0, 32'h504, LW);          // lw x2, 0(x1)
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall1 got=%b want 1", stall); end
    tick(); exp_cnt++;
    checks++; if (stall !== 1'b0 || ex_ctrl !== '0) begin failures++; $display("FAIL b2b_bubble1 stall=%b ctrl=%0h want 0/0", stall, ex_ctrl); end
    tick();
    checks++; if (ex_memr !== 1'b1 || ex_rd !== 5'd2) begin failures++; $display("FAIL b2b_load2 memr=%b rd=%0d want 1/2", ex_memr, ex_rd); end
    set_id(5'd2, 5'd2, 5'd3, 1, 1, 32'h508, ADD);         // add x3, x2, x2
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall2 got=%b want 1", stall); end
    tick(); exp_cnt++;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_double got=%b want 0", stall); end
    tick();
    checks++; if (ex_ctrl !== ADD || ex_rd !== 5'd3 || cnt !== exp_cnt) begin failures++; $display("FAIL b2b_capture ctrl=%0h rd=%0d cnt=%0d want %0h/3/%0d", ex_ctrl, ex_rd, cnt, ADD, exp_cnt); end
  endtask

  task automatic test_saturate();
    logic [1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    set_id(5'd0, 5'd0, 5'd0, 0, 0, 32'h0, '0);
    rst_sat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_id(5'd2, 5'd0, 5'd5, 1, 0, 32'h600 + 32'(i * 16), LW);
      tick();
      set_id(5'd4, 5'd5, 5'd6, 1, 1, 32'h604 + 32'(i * 16), ADD);  // reads x5 via rs2
      tick(); exp_cnt++;
      checks++; if (s_cnt !== want[i]) begin failures++; $display("FAIL sat_count[%0d] got=%0d want %0d", i, s_cnt, want[i]); end
      tick();
    end
    checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL sat_wide_count got=%0d want %0d", cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd2, 5'd0, 5'd5, 1, 0, 32'h700, LW);
    tick();
    set_id(5'd5, 5'd0, 5'd9, 1, 0, 32'h704, ADDI);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rms_stall got=%b want 1", stall); end
    rst = 1'b1; #1;
    exp_cnt = '0;
    checks++; if (ex_ctrl !== '0 || ex_rd !== '0 || ex_pc !== '0 || ex_imm !== '0 || cnt !== '0) begin failures++; $display("FAIL rms_async ctrl=%0h rd=%0d pc=%0h imm=%0h cnt=%0d want 0", ex_ctrl, ex_rd, ex_pc, ex_imm, cnt); end
    checks++; if (stall !== 1'b0 || pc_write !== 1'b1) begin failures++; $display("FAIL rms_ctl stall=%b pcw=%b want 0/1", stall, pc_write); end
    rst = 1'b0; #1;
    tick();
    checks++; if (ex_ctrl !== ADDI || ex_rd !== 5'd9 || ex_pc !== 32'h704 || cnt !== '0) begin failures++; $display("FAIL rms_resume ctrl=%0h rd=%0d pc=%0h cnt=%0d", ex_ctrl, ex_rd, ex_pc, cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_unused_src();
    test_x0_and_flush();
    test_back_to_back();
    test_saturate();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
